// File: rtl/msi_mem_pkg.sv
// Shared definitions for the MSI main-memory path: bus widths and the
// arbiter state encodings used by mem_bus_arbiter and the cache controllers.
package msi_mem_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_ACCESS = 2'd1;
    localparam logic [1:0] ARB_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ARB_IDLE,
        ACCESS = ARB_ACCESS,
        RESP   = ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // Scan positions ptr, ptr+1, ... modulo N_REQ and take the first requester.
    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!valid && req[PTR_W'(pos)]) begin
                valid              = 1'b1;
                grant[PTR_W'(pos)] = 1'b1;
                idx                = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single main memory among N_REQ cache controllers. One access at
// a time: IDLE picks a winner round-robin, ACCESS drives the memory strobes
// until ready (or timeout), RESP presents the done/err pulse for one cycle.
//
// Handshake: a requester raises req and holds it until its done pulse; gnt
// is high from the grant edge through the RESP cycle; done (and err on a
// timeout) is high for exactly the RESP cycle. Request fields are latched at
// the grant edge, so later changes on req_* are ignored for that access.
module mem_bus_arbiter
    import msi_mem_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*MEM_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*MEM_DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic                        err,
    output logic [MEM_DATA_W-1:0]       rdata,
    output logic [MEM_ADDR_W-1:0]       mem_addr,
    inout  wire  [MEM_DATA_W-1:0]       mem_data,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic                        mem_cs,
    input  logic                        mem_ready,
    output logic [1:0]                  dbg_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t              state_q;
    arb_state_t              state_d;
    logic [N_REQ-1:0]        win_grant;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_valid;
    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        owner_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [MEM_ADDR_W-1:0]   addr_q;
    logic                    we_q;
    logic [MEM_DATA_W-1:0]   wdata_q;
    logic [MEM_ADDR_W-1:0]   sel_addr;
    logic                    sel_we;
    logic [MEM_DATA_W-1:0]   sel_wdata;
    logic                    take;
    logic                    finish;
    logic                    timeout_hit;
    logic                    release_bus;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Route the winning requester's fields to the latch inputs.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_grant[i]) begin
                sel_addr  = req_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
                sel_we    = req_we[i];
                sel_wdata = req_wdata[i*MEM_DATA_W +: MEM_DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and memory strobes; strobes are held for the whole ACCESS.
    always_comb begin
        state_d     = state_q;
        take        = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        release_bus = 1'b0;
        mem_cs      = 1'b0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ACCESS;
                    take    = 1'b1;
                end
            end
            ACCESS: begin
                mem_cs = 1'b1;
                mem_wr = we_q;
                mem_rd = ~we_q;
                if (mem_ready) begin
                    state_d = RESP;
                    finish  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    finish      = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                release_bus = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant latches, timeout counter, completion pulses and rr pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (take) begin
                gnt     <= win_grant;
                addr_q  <= sel_addr;
                we_q    <= sel_we;
                wdata_q <= sel_wdata;
                owner_q <= win_idx;
                cnt_q   <= '0;
            end
            if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                done <= gnt;
                err  <= timeout_hit;
                if (!timeout_hit && !we_q) begin
                    rdata <= mem_data;
                end
            end
            if (release_bus) begin
                gnt   <= '0;
                done  <= '0;
                err   <= 1'b0;
                ptr_q <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_data  = (mem_cs && mem_wr) ? wdata_q : {MEM_DATA_W{1'bz}};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with a small registered-ready memory model.
module tb_mem_bus_arbiter;
    import msi_mem_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     req_we;
    logic [N_REQ*6-1:0]   req_addr;
    logic [N_REQ*32-1:0]  req_wdata;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     done;
    logic                 err;
    logic [31:0]          rdata;
    logic [5:0]           mem_addr;
    wire  [31:0]          mem_data;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 mem_cs;
    logic                 mem_ready;
    logic [1:0]           dbg_state;

    mem_bus_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_cs    (mem_cs),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] rd_q;
    logic        mem_disc;

    assign mem_data = (mem_cs && mem_rd && !mem_disc) ? rd_q : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (mem_cs && !mem_disc) begin
            mem_ready <= 1'b1;
            rd_q      <= mem[mem_addr];
            if (mem_wr) mem[mem_addr] <= mem_data;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input bit we, input logic [5:0] a, input logic [31:0] d);
        req_we[r]            = we;
        req_addr[r*6 +: 6]   = a;
        req_wdata[r*32 +: 32] = d;
        req[r]               = 1'b1;
    endtask

    task automatic wait_gnt(output int idx, output int t);
        int n;
        n   = 0;
        idx = 0;
        while (gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt: no grant within 40 cycles");
        end else begin
            for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
        end
        t = cyc;
    endtask

    task automatic wait_done(input int limit, output int t);
        int n;
        n = 0;
        while (done == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done == '0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
        t = cyc;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
    endtask

    // One complete access by a lone requester, checked from grant to release.
    task automatic run_single(input int r, input bit we, input logic [5:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rd,
                              input bit exp_err, input string nm);
        int w, tg, td;
        set_req(r, we, a, d);
        wait_gnt(w, tg);
        check({nm, " gnt"}, 32'(gnt), 32'(1) << r);
        check({nm, " access strobes"}, {29'd0, mem_cs, mem_wr, mem_rd}, {29'd0, 1'b1, we, ~we});
        check({nm, " mem_addr"}, 32'(mem_addr), 32'(a));
        if (we) check({nm, " mem_data"}, mem_data, d);
        wait_done(TIMEOUT + 4, td);
        check({nm, " latency"}, 32'(td - tg), exp_err ? 32'(TIMEOUT) : 32'd2);
        check({nm, " done"}, 32'(done), 32'(1) << r);
        check({nm, " err"}, 32'(err), 32'(exp_err));
        check({nm, " rdata"}, rdata, exp_rd);
        check({nm, " resp state"}, 32'(dbg_state), 32'(ARB_RESP));
        if (!exp_err && we) ref_mem[a] = d;
        if (!exp_err && !we) last_rd = exp_rd;
        req[r] = 1'b0;
        @(negedge clk);
        check({nm, " release"}, {26'd0, gnt, done, err, mem_cs}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          who;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    // ---------------- main sequence ----------------
    initial begin
        int w, tg, td, prev_t, exp_w, ii;
        bit nodone;
        bit pending [N_REQ];
        bit p_we    [N_REQ];
        logic [5:0]  p_addr [N_REQ];
        logic [31:0] p_data [N_REQ];
        int model_ptr;
        logic [31:0] e;

        vecs[0] = '{0, 1'b1, 6'd5,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{0, 1'b0, 6'd5,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1, 1'b1, 6'd0,  32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{3, 1'b1, 6'd63, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{2, 1'b0, 6'd0,  32'h0,         32'h1234_5678, 1'b0};
        vecs[5] = '{1, 1'b0, 6'd63, 32'h0,         32'hA5A5_5A5A, 1'b0};
        vecs[6] = '{3, 1'b1, 6'd5,  32'h0000_0000, 32'hA5A5_5A5A, 1'b0};
        vecs[7] = '{0, 1'b0, 6'd5,  32'h0,         32'h0000_0000, 1'b0};

        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rd_q      = 32'h0;
        mem_ready = 1'b0;
        mem_disc  = 1'b0;
        last_rd   = 32'h0;
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset gnt",   32'(gnt),       32'd0);
        check("reset done",  32'(done),      32'd0);
        check("reset err",   32'(err),       32'd0);
        check("reset strobes", {29'd0, mem_cs, mem_rd, mem_wr}, 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset rdata", rdata,          32'd0);
        check("reset state", 32'(dbg_state), 32'(ARB_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Write/read table, includes write 0xDEADBEEF then read at addr 5
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Contention: four simultaneous reads served 0,1,2,3, 4 cycles apart
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            mem[i]     = 32'(i) * 32'h11;
            ref_mem[i] = 32'(i) * 32'h11;
        end
        for (int r = 0; r < 4; r++) set_req(r, 1'b0, 6'(r + 1), 32'h0);
        prev_t = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w, tg);
            check($sformatf("contend order %0d", k), 32'(w), 32'(k));
            if (k > 0) check($sformatf("contend spacing %0d", k), 32'(tg - prev_t), 32'd4);
            prev_t = tg;
            wait_done(8, td);
            check($sformatf("contend rdata %0d", k), rdata, ref_mem[k + 1]);
            req[w] = 1'b0;
            @(negedge clk);
        end

        // Fairness: req0 and req2 held continuously
        pulse_reset();
        mem[7] = 32'h77; ref_mem[7] = 32'h77;
        mem[9] = 32'h99; ref_mem[9] = 32'h99;
        set_req(0, 1'b0, 6'd7, 32'h0);
        set_req(2, 1'b0, 6'd9, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_gnt(w, tg);
            check($sformatf("fair order %0d", k), 32'(w), (k % 2 == 0) ? 32'd0 : 32'd2);
            wait_done(8, td);
            check($sformatf("fair rdata %0d", k), rdata, (k % 2 == 0) ? 32'h77 : 32'h99);
            if (k == 5) req = '0;
            @(negedge clk);
        end
        last_rd = 32'h99;

        // Timeout: memory disconnected, ready stuck low
        mem_disc = 1'b1;
        run_single(3, 1'b0, 6'd12, 32'h0, last_rd, 1'b1, "timeout");
        mem_disc = 1'b0;

        // Reset in the ACCESS cycle of a write
        set_req(1, 1'b1, 6'd20, 32'hCAFE_0001);
        wait_gnt(w, tg);
        check("midrst in access", 32'(mem_cs), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        ref_mem[20] = 32'hCAFE_0001;
        check("midrst gnt",   32'(gnt),  32'd0);
        check("midrst bus",   {29'd0, mem_cs, mem_wr, mem_rd}, 32'd0);
        check("midrst done",  32'(done), 32'd0);
        check("midrst state", 32'(dbg_state), 32'(ARB_IDLE));
        rst = 1'b0;
        req = '0;
        last_rd = 32'h0;
        nodone = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done != '0) nodone = 1'b0;
        end
        check("midrst no done", 32'(nodone), 32'd1);
        run_single(2, 1'b0, 6'd1, 32'h0, 32'h11, 1'b0, "post reset read");

        // Early req drop and address change after grant
        run_single(1, 1'b1, 6'd33, 32'h0BAD_F00D, last_rd, 1'b0, "drop prep");
        set_req(1, 1'b0, 6'd33, 32'h0);
        wait_gnt(w, tg);
        req[1] = 1'b0;
        req_addr[6 +: 6] = 6'd40;
        @(negedge clk);
        check("drop mem_addr", 32'(mem_addr), 32'd33);
        wait_done(8, td);
        check("drop done", 32'(done), 32'b0010);
        check("drop rdata", rdata, 32'h0BAD_F00D);
        @(negedge clk);

        // Randomized traffic against the round-robin reference model
        pulse_reset();
        model_ptr = 0;
        for (int r = 0; r < N_REQ; r++) pending[r] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!pending[r] && $urandom_range(0, 1) == 1) pending[r] = 1'b1;
            end
            ii = $urandom_range(0, N_REQ - 1);
            pending[ii] = 1'b1;
            for (int r = 0; r < N_REQ; r++) begin
                if (pending[r] && !req[r]) begin
                    p_we[r]   = ($urandom_range(0, 1) == 1);
                    p_addr[r] = 6'($urandom_range(0, 63));
                    p_data[r] = $urandom;
                    set_req(r, p_we[r], p_addr[r], p_data[r]);
                end
            end
            exp_w = -1;
            for (int k = 0; k < N_REQ; k++) begin
                ii = (model_ptr + k) % N_REQ;
                if (pending[ii] && exp_w < 0) exp_w = ii;
            end
            wait_gnt(w, tg);
            check($sformatf("rand %0d winner", t), 32'(w), 32'(exp_w));
            check($sformatf("rand %0d mem_addr", t), 32'(mem_addr), 32'(p_addr[w]));
            if (p_we[w]) check($sformatf("rand %0d mem_data", t), mem_data, p_data[w]);
            else exp_q.push_back(ref_mem[p_addr[w]]);
            if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
            req_addr[w*6 +: 6] = 6'($urandom_range(0, 63));
            wait_done(8, td);
            check($sformatf("rand %0d latency", t), 32'(td - tg), 32'd2);
            check($sformatf("rand %0d done", t), {27'd0, err, done}, 32'(1) << w);
            if (!p_we[w]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                check($sformatf("rand %0d rdata", t), rdata, e);
                last_rd = e;
            end else begin
                check($sformatf("rand %0d rdata held", t), rdata, last_rd);
                ref_mem[p_addr[w]] = p_data[w];
            end
            req[w]     = 1'b0;
            pending[w] = 1'b0;
            model_ptr  = (w + 1) % N_REQ;
            @(negedge clk);
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
